// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter sharing one SPI burst-capture engine between NUM_REQ clients.
// Optional watchdog: define SPI_BURST_ARB_TIMEOUT_EN to abort stuck transactions after TIMEOUT_CYCLES.
module spi_burst_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [16*NUM_REQ-1:0] i_req_burst_count,
   input  logic                 i_cap_busy,
   output logic                 o_start,
   output logic [15:0]          o_burst_count,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [NUM_REQ-1:0]   o_ack,
   output logic                 o_err,
   output logic                 o_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_GRANT     = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_RELEASE   = 3'd4;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("spi_burst_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
   end

   logic [2:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               err_q, err_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic [15:0]        count_q, count_d;
   logic               cause_q, cause_d;
`ifdef SPI_BURST_ARB_TIMEOUT_EN
   logic [31:0]        timer_q, timer_d;
`endif

   logic               found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cand;
   int                 idx;
   logic [15:0]        win_count;
   logic [NUM_REQ-1:0] win_onehot;

   // Search starts one past the last winner so the previous owner is considered last.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx  = (int'(ptr_q) + i) % NUM_REQ;
         cand = PTR_W'(idx);
         if (!found && i_req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign win_count  = i_req_burst_count[{win_idx, 4'b0000} +: 16];
   assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

   // Handshake: i_req is a level held by the client until its o_ack pulse and is only
   // sampled in IDLE; o_start and o_ack/o_err are single-cycle pulses.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      count_d = count_q;
      cause_d = cause_q;
`ifdef SPI_BURST_ARB_TIMEOUT_EN
      timer_d = timer_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               ptr_d   = win_idx;
               grant_d = win_onehot;
               count_d = win_count;
               if (win_count != 16'd0) begin
                  state_d = ST_GRANT;
                  cause_d = 1'b0;
               end else begin
                  state_d = ST_RELEASE;
                  cause_d = 1'b1;
               end
            end
         end
         ST_GRANT: begin
            state_d = ST_WAIT_BUSY;
`ifdef SPI_BURST_ARB_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         ST_WAIT_BUSY, ST_WAIT_DONE: begin
            if (state_q == ST_WAIT_BUSY && i_cap_busy) begin
               state_d = ST_WAIT_DONE;
            end
            if (state_q == ST_WAIT_DONE && !i_cap_busy) begin
               state_d = ST_RELEASE;
            end
`ifdef SPI_BURST_ARB_TIMEOUT_EN
            if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_RELEASE;
               cause_d = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
`endif
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Pulse outputs are decoded from the next state so they line up with the state they describe.
   always_comb begin
      start_d = (state_d == ST_GRANT);
      ack_d   = (state_d == ST_RELEASE) ? grant_d : '0;
      err_d   = (state_d == ST_RELEASE) && cause_d;
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         grant_q <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= '0;
         cause_q <= 1'b0;
`ifdef SPI_BURST_ARB_TIMEOUT_EN
         timer_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         cause_q <= cause_d;
`ifdef SPI_BURST_ARB_TIMEOUT_EN
         timer_q <= timer_d;
`endif
      end
   end

   assign o_start       = start_q;
   assign o_burst_count = count_q;
   assign o_grant       = grant_q;
   assign o_ack         = ack_q;
   assign o_err         = err_q;
   assign o_busy        = busy_q;

endmodule
